uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver feeding a 6-byte framer: a 4-byte header, then a 16-bit payload.
// Reports good frames, stop-bit errors and header mismatches as one-cycle pulses.
module uart_rx_frame #(
  parameter int          CLK_DIV  = 2500,
  parameter logic [31:0] HDR      = 32'hAA07_0200,
  parameter int          GAP_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_rx,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        hdr_err,
  output logic        busy
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_BITS * CLK_DIV + 1);
  localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL    = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_BITS * CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic          meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hi_q, hi_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          hdr_err_q, hdr_err_d;
  logic          strobe, start_edge;
  logic [7:0]    exp_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      gap_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      meta_q       <= line_rx;
      rx_s_q       <= meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      gap_q        <= gap_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_s_q;

  // Bit-level FSM: all sampling at mid-bit, timed from the detected start edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    strobe      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (rx_s_q) strobe = 1'b1;
        else        frame_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q[1:0])
      2'd0:    exp_b = HDR[31:24];
      2'd1:    exp_b = HDR[23:16];
      2'd2:    exp_b = HDR[15:8];
      default: exp_b = HDR[7:0];
    endcase
  end

  // Framer: header match, payload capture, inter-byte timeout.
  always_comb begin
    idx_d        = idx_q;
    hi_d         = hi_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    hdr_err_d    = 1'b0;
    if (frame_err_d) begin
      idx_d = '0;
    end else if (strobe) begin
      if (idx_q < 3'd4) begin
        if (shift_q == exp_b) begin
          idx_d = idx_q + 3'd1;
        end else begin
          hdr_err_d = 1'b1;
          idx_d     = (shift_q == HDR[31:24]) ? 3'd1 : 3'd0;
        end
      end else if (idx_q == 3'd4) begin
        hi_d  = shift_q;
        idx_d = 3'd5;
      end else begin
        data_out_d   = {hi_q, shift_q};
        data_valid_d = 1'b1;
        idx_d        = '0;
      end
    end else if (gap_q == GAP_LIM) begin
      idx_d = '0;
    end

    gap_d = gap_q;
    if (start_edge || idx_q == 3'd0 || gap_q == GAP_LIM) gap_d = '0;
    else if (state_q == IDLE)                            gap_d = gap_q + 1'b1;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign hdr_err    = hdr_err_q;
  assign busy       = (state_q != IDLE) || (idx_q != 3'd0);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames plus random byte streams, checked
// against a byte-level framing model that predicts the ordered pulse sequence.
module tb_uart_rx_frame;
  localparam int          CD   = 16;
  localparam int          GAPB = 20;
  localparam logic [31:0] HDRP = 32'hAA07_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_rx = 1'b1;
  logic [15:0] data_out;
  logic        data_valid, frame_err, hdr_err, busy;

  uart_rx_frame #(.CLK_DIV(CD), .HDR(HDRP), .GAP_BITS(GAPB)) dut (
    .clk(clk), .rst_n(rst_n), .line_rx(line_rx), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .hdr_err(hdr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_VALID = 3'b100, EV_FERR = 3'b010, EV_HDR = 3'b001} ev_e;
  typedef struct { ev_e kind; logic [15:0] data; } ev_t;

  ev_t         exp_q[$];
  int          nchk = 0, nerr = 0;
  int          dv_cnt = 0, fe_cnt = 0, he_cnt = 0;
  logic [15:0] exp_dout = '0;
  int          m_idx = 0;
  logic [7:0]  m_hi = '0;
  int          last_idle = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hb(input int i);
    logic [31:0] h;
    h = HDRP;
    return h[31-8*i -: 8];
  endfunction

  // Byte-level view of the framer: what each received byte must cause.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.data = '0;
    if (last_idle >= GAPB) m_idx = 0;
    if (!stop_ok) begin
      e.kind = EV_FERR; exp_q.push_back(e); m_idx = 0;
    end else if (m_idx < 4) begin
      if (b == hb(m_idx)) m_idx++;
      else begin
        e.kind = EV_HDR; exp_q.push_back(e);
        m_idx = (b == hb(0)) ? 1 : 0;
      end
    end else if (m_idx == 4) begin
      m_hi = b; m_idx = 5;
    end else begin
      e.kind = EV_VALID; e.data = {m_hi, b}; exp_q.push_back(e); m_idx = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input int idle_bits);
    model_byte(b, stop_ok);
    line_rx = 1'b0; tick(CD);
    for (int i = 0; i < 8; i++) begin line_rx = b[i]; tick(CD); end
    line_rx = stop_ok; tick(CD);
    line_rx = 1'b1; tick(idle_bits * CD);
    last_idle = idle_bits;
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin exp_dout = '0; continue; end
      chk("pulse_exclusive", 32'(int'(data_valid) + int'(frame_err) + int'(hdr_err) > 1), 0);
      if (data_valid || frame_err || hdr_err) begin
        if (data_valid) dv_cnt++;
        if (frame_err)  fe_cnt++;
        if (hdr_err)    he_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'b0, data_valid, frame_err, hdr_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'b0, data_valid, frame_err, hdr_err}, {29'b0, e.kind});
          if (e.kind == EV_VALID) exp_dout = e.data;
        end
      end
      chk("data_out", {16'b0, data_out}, {16'b0, exp_dout});
    end
  endtask

  task automatic settle();
    tick(3 * CD);
    chk("pending_events", exp_q.size(), 0);
  endtask

  int dv0, fe0, he0;
  logic [7:0] fb[6];

  initial begin
    fork monitor(); join_none

    tick(4);
    chk("rst_data_out", {16'b0, data_out}, 0);
    chk("rst_pulses", {29'b0, data_valid, frame_err, hdr_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1; tick(2 * CD);

    // Good frame
    dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send(8'hAA, 1, 0); send(8'h07, 1, 1); send(8'h02, 1, 0);
    send(8'h00, 1, 2); send(8'h12, 1, 0); send(8'h34, 1, 2);
    settle();
    chk("good_dv", dv_cnt - dv0, 1);
    chk("good_errs", (fe_cnt - fe0) + (he_cnt - he0), 0);
    chk("good_dout", {16'b0, data_out}, 32'h1234);
    chk("good_busy", {31'b0, busy}, 0);

    // Header mismatch on third byte; the trailing bytes also miss HDR[31:24]
    dv0 = dv_cnt; he0 = he_cnt;
    send(8'hAA, 1, 0); send(8'h07, 1, 0); send(8'h03, 1, 0);
    send(8'h00, 1, 0); send(8'h12, 1, 0); send(8'h34, 1, 1);
    settle();
    chk("hdr_dv", dv_cnt - dv0, 0);
    chk("hdr_cnt", he_cnt - he0, 4);
    chk("hdr_dout_hold", {16'b0, data_out}, 32'h1234);

    // Stop-bit error, then resync through a stray byte
    dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send(8'hAA, 1, 0); send(8'h07, 0, 1);
    send(8'h55, 1, 0); send(8'hAA, 1, 0); send(8'h07, 1, 0); send(8'h02, 1, 0);
    send(8'h00, 1, 0); send(8'hBE, 1, 0); send(8'hEF, 1, 1);
    settle();
    chk("ferr_cnt", fe_cnt - fe0, 1);
    chk("ferr_hdr_cnt", he_cnt - he0, 1);
    chk("ferr_dv", dv_cnt - dv0, 1);
    chk("ferr_dout", {16'b0, data_out}, 32'hBEEF);

    // Glitch shorter than half a bit is a false start
    dv0 = dv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    line_rx = 1'b0; tick(5);
    chk("glitch_busy_mid", {31'b0, busy}, 1);
    line_rx = 1'b1; tick(2 * CD);
    chk("glitch_busy", {31'b0, busy}, 0);
    chk("glitch_pulses", (dv_cnt - dv0) + (fe_cnt - fe0) + (he_cnt - he0), 0);

    // Inter-byte timeout drops a partial header
    dv0 = dv_cnt; he0 = he_cnt;
    send(8'hAA, 1, 0); send(8'h07, 1, 1);
    chk("gap_busy_partial", {31'b0, busy}, 1);
    tick(20 * CD); last_idle = 21;
    chk("gap_busy_cleared", {31'b0, busy}, 0);
    send(8'h02, 1, 0); send(8'h00, 1, 0); send(8'h12, 1, 0); send(8'h34, 1, 1);
    settle();
    chk("gap_dv", dv_cnt - dv0, 0);
    chk("gap_hdr_cnt", he_cnt - he0, 4);

    // Reset in the middle of the high payload byte
    send(8'hAA, 1, 0); send(8'h07, 1, 0); send(8'h02, 1, 0); send(8'h00, 1, 0);
    line_rx = 1'b0; tick(CD);
    line_rx = 1'b0; tick(CD); line_rx = 1'b1; tick(CD); line_rx = 1'b0; tick(CD / 2);
    chk("pre_reset_pending", exp_q.size(), 0);
    rst_n = 1'b0; line_rx = 1'b1; tick(3);
    chk("mid_rst_data_out", {16'b0, data_out}, 0);
    chk("mid_rst_pulses", {29'b0, data_valid, frame_err, hdr_err}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    m_idx = 0; last_idle = 100;
    rst_n = 1'b1; tick(2 * CD);
    dv0 = dv_cnt;
    send(8'hAA, 1, 0); send(8'h07, 1, 0); send(8'h02, 1, 0);
    send(8'h00, 1, 0); send(8'h00, 1, 0); send(8'h01, 1, 1);
    settle();
    chk("rst_frame_dv", dv_cnt - dv0, 1);
    chk("rst_frame_dout", {16'b0, data_out}, 32'h0001);

    // Random streams: mostly well-formed frames with injected faults
    for (int f = 0; f < 12; f++) begin
      fb[0] = 8'hAA; fb[1] = 8'h07; fb[2] = 8'h02; fb[3] = 8'h00;
      fb[4] = 8'($urandom); fb[5] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        int r, g, idle;
        logic [7:0] b;
        bit ok;
        r = $urandom_range(0, 99);
        b = (r < 8) ? 8'($urandom) : fb[i];
        ok = !(r >= 8 && r < 12);
        g = $urandom_range(0, 9);
        idle = (g == 0) ? 25 : g % 4;
        if (!ok && idle == 0) idle = 1;
        send(b, ok, idle);
      end
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
